egpio: RTL and testbench

EGPIO -- requirements
Module: egpio

---
 rtl/egpio.sv | 183 ++++++++++++++++++
 tb/tb_egpio.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/egpio.sv
// egpio: emesh-mapped GPIO block with per-pin edge/level interrupt latching.
// Optional feature macro GPIO_IRQ_BOTHEDGE_EN adds register 10 (IBOTH, either-edge latching).
module egpio #(
  parameter int N  = 32,
  parameter int AW = 32,
  parameter int PW = 104
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          access_in,
  input  logic [PW-1:0] packet_in,
  output logic          wait_out,
  output logic          access_out,
  output logic [PW-1:0] packet_out,
  input  logic          wait_in,
  input  logic [N-1:0]  gpio_in,
  output logic [N-1:0]  gpio_out,
  output logic [N-1:0]  gpio_dir,
  output logic          gpio_irq
);

  localparam int DST_LSB  = 8;
  localparam int DATA_LSB = 8 + AW;
  localparam int SRC_LSB  = 8 + 2 * AW;

  typedef enum logic [3:0] {
    REG_OUT    = 4'd0,
    REG_DIR    = 4'd1,
    REG_IN     = 4'd2,
    REG_OUTSET = 4'd3,
    REG_OUTCLR = 4'd4,
    REG_OUTXOR = 4'd5,
    REG_IMASK  = 4'd6,
    REG_ITYPE  = 4'd7,
    REG_IPOL   = 4'd8,
    REG_ILAT   = 4'd9,
    REG_IBOTH  = 4'd10
  } reg_idx_e;

  logic [N-1:0]  out_q, dir_q, imask_q, itype_q, ipol_q, ilat_q;
  logic [N-1:0]  sync1_q, sync2_q, prev_q;
  logic [2:0]    arm_q;
  logic          irq_q;
`ifdef GPIO_IRQ_BOTHEDGE_EN
  logic [N-1:0]  iboth_q;
`endif

  logic          accept, wr_en, rd_en, edge_armed;
  reg_idx_e      idx;
  logic [N-1:0]  wdata, rise, fall, edge_hit, ilat_clr, ilat_d, rreg;
  logic [AW-1:0] rdata;
  logic [PW-1:0] resp_pkt;
  logic          unused_pkt;

  assign unused_pkt = ^packet_in;

  assign wait_out = access_out & wait_in;
  assign accept   = access_in & ~wait_out;
  assign wr_en    = accept & packet_in[0];
  assign rd_en    = accept & ~packet_in[0];
  assign idx      = reg_idx_e'(packet_in[DST_LSB+3 +: 4]);
  assign wdata    = packet_in[DATA_LSB +: N];

  assign gpio_out = out_q;
  assign gpio_dir = dir_q;
  assign gpio_irq = irq_q;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      out_q   <= '0;
      dir_q   <= '0;
      imask_q <= '0;
      itype_q <= '0;
      ipol_q  <= '0;
`ifdef GPIO_IRQ_BOTHEDGE_EN
      iboth_q <= '0;
`endif
    end else if (wr_en) begin
      case (idx)
        REG_OUT:    out_q   <= wdata;
        REG_DIR:    dir_q   <= wdata;
        REG_OUTSET: out_q   <= out_q | wdata;
        REG_OUTCLR: out_q   <= out_q & ~wdata;
        REG_OUTXOR: out_q   <= out_q ^ wdata;
        REG_IMASK:  imask_q <= wdata;
        REG_ITYPE:  itype_q <= wdata;
        REG_IPOL:   ipol_q  <= wdata;
`ifdef GPIO_IRQ_BOTHEDGE_EN
        REG_IBOTH:  iboth_q <= wdata;
`endif
        default:    ;
      endcase
    end
  end

  // arm_q delays edge detection until prev_q holds a real pin sample, so a pin
  // already high across reset is not seen as a rising edge.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
      arm_q   <= '0;
    end else begin
      sync1_q <= gpio_in;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      arm_q   <= {arm_q[1:0], 1'b1};
    end
  end

  assign edge_armed = arm_q[2];

  always_comb begin
    rise = sync2_q & ~prev_q;
    fall = ~sync2_q & prev_q;
`ifdef GPIO_IRQ_BOTHEDGE_EN
    edge_hit = (iboth_q & (rise | fall)) |
               (~iboth_q & ((ipol_q & rise) | (~ipol_q & fall)));
`else
    edge_hit = (ipol_q & rise) | (~ipol_q & fall);
`endif
    if (!edge_armed) edge_hit = '0;
    ilat_clr = (wr_en && idx == REG_ILAT) ? wdata : '0;
    // set beats clear for edge bits; level bits track the pin every cycle
    ilat_d = (itype_q & (edge_hit | (ilat_q & ~ilat_clr))) |
             (~itype_q & ~(sync2_q ^ ipol_q));
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      ilat_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      ilat_q <= ilat_d;
      irq_q  <= |(ilat_q & ~imask_q);
    end
  end

  // OUTSET/OUTCLR/OUTXOR are aliases of OUT and read back its value
  always_comb begin
    rreg = '0;
    case (idx)
      REG_OUT, REG_OUTSET, REG_OUTCLR, REG_OUTXOR: rreg = out_q;
      REG_DIR:   rreg = dir_q;
      REG_IN:    rreg = sync2_q;
      REG_IMASK: rreg = imask_q;
      REG_ITYPE: rreg = itype_q;
      REG_IPOL:  rreg = ipol_q;
      REG_ILAT:  rreg = ilat_q;
`ifdef GPIO_IRQ_BOTHEDGE_EN
      REG_IBOTH: rreg = iboth_q;
`endif
      default:   rreg = '0;
    endcase
    rdata = '0;
    rdata[N-1:0] = rreg;
  end

  always_comb begin
    resp_pkt = '0;
    resp_pkt[0]   = 1'b1;
    resp_pkt[2:1] = packet_in[2:1];
    resp_pkt[7:3] = packet_in[7:3];
    resp_pkt[DST_LSB +: AW]  = packet_in[SRC_LSB +: AW];
    resp_pkt[DATA_LSB +: AW] = rdata;
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      access_out <= 1'b0;
      packet_out <= '0;
    end else if (access_out && wait_in) begin
      access_out <= 1'b1;
    end else if (rd_en) begin
      access_out <= 1'b1;
      packet_out <= resp_pkt;
    end else begin
      access_out <= 1'b0;
    end
  end

endmodule

// File: tb/tb_egpio.sv
// tb_egpio: scoreboard bench for egpio with a transaction-level reference model.
module tb_egpio;
  localparam int N  = 16;
  localparam int AW = 32;
  localparam int PW = 104;

  logic          clk = 1'b0;
  logic          nreset, access_in, wait_in;
  logic [PW-1:0] packet_in;
  logic          wait_out, access_out;
  logic [PW-1:0] packet_out;
  logic [N-1:0]  gpio_in, gpio_out, gpio_dir;
  logic          gpio_irq;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  egpio #(.N(N), .AW(AW), .PW(PW)) dut (
    .clk(clk), .nreset(nreset), .access_in(access_in), .packet_in(packet_in),
    .wait_out(wait_out), .access_out(access_out), .packet_out(packet_out),
    .wait_in(wait_in), .gpio_in(gpio_in), .gpio_out(gpio_out),
    .gpio_dir(gpio_dir), .gpio_irq(gpio_irq)
  );

  // reference model state
  logic [N-1:0]  m_out, m_dir, m_imask, m_itype, m_ipol, m_ilat, m_iboth;
  logic          m_irq, m_valid;
  logic [N-1:0]  pin_q[$];
  logic [PW-1:0] exp_q[$];

  task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s", name);
  endtask

  function automatic logic [N-1:0] pin_ago(input int k);
    if (k < pin_q.size()) return pin_q[k];
    return '0;
  endfunction

  function automatic logic [31:0] reg_val(input int idx, input logic [N-1:0] s_now);
    logic [N-1:0] v;
    logic [31:0]  r;
    case (idx)
      0, 3, 4, 5: v = m_out;
      1:          v = m_dir;
      2:          v = s_now;
      6:          v = m_imask;
      7:          v = m_itype;
      8:          v = m_ipol;
      9:          v = m_ilat;
`ifdef GPIO_IRQ_BOTHEDGE_EN
      10:         v = m_iboth;
`endif
      default:    v = '0;
    endcase
    r = '0;
    r[N-1:0] = v;
    return r;
  endfunction

  function automatic logic [PW-1:0] resp_of(input logic [PW-1:0] req, input logic [31:0] d);
    logic [PW-1:0] r;
    r = '0;
    r[0]      = 1'b1;
    r[2:1]    = req[2:1];
    r[7:3]    = req[7:3];
    r[39:8]   = req[103:72];
    r[71:40]  = d;
    return r;
  endfunction

  function automatic logic [PW-1:0] make_pkt(input bit wr, input int idx,
                                             input logic [31:0] data, input logic [31:0] src);
    logic [PW-1:0] p;
    logic [31:0]   dst, rnd;
    logic [3:0]    ix;
    ix  = idx[3:0];
    dst = $urandom;
    dst[6:3] = ix;
    rnd = $urandom;
    p = '0;
    p[0]      = wr;
    p[2:1]    = rnd[1:0];
    p[7:3]    = rnd[6:2];
    p[39:8]   = dst;
    p[71:40]  = data;
    p[103:72] = src;
    return p;
  endfunction

  // One clock of the model: pins are seen two edges late, ILAT follows the
  // edge/level rules, irq trails ILAT by one edge, reads answer next cycle.
  task automatic model_step();
    logic [N-1:0] s_now, s_prev, nl, wd;
    logic         acc, wr, rose, fell, hit, armed;
    int           idx;
    if (!nreset) begin
      m_out = '0; m_dir = '0; m_imask = '0; m_itype = '0; m_ipol = '0;
      m_ilat = '0; m_iboth = '0; m_irq = 1'b0; m_valid = 1'b0;
      pin_q.delete();
      exp_q.delete();
      return;
    end
    s_now  = pin_ago(1);
    s_prev = pin_ago(2);
    armed  = (pin_q.size() >= 3);
    acc    = access_in && !(m_valid && wait_in);
    wr     = packet_in[0];
    idx    = int'(packet_in[14:11]);
    wd     = packet_in[40 +: N];
    for (int i = 0; i < N; i++) begin
      if (!m_itype[i]) begin
        nl[i] = (s_now[i] == m_ipol[i]);
      end else begin
        rose = s_now[i] && !s_prev[i];
        fell = !s_now[i] && s_prev[i];
`ifdef GPIO_IRQ_BOTHEDGE_EN
        if (m_iboth[i]) hit = rose || fell;
        else            hit = m_ipol[i] ? rose : fell;
`else
        hit = m_ipol[i] ? rose : fell;
`endif
        hit = hit && armed;
        if (hit) nl[i] = 1'b1;
        else if (acc && wr && idx == 9 && wd[i]) nl[i] = 1'b0;
        else nl[i] = m_ilat[i];
      end
    end
    m_irq = |(m_ilat & ~m_imask);
    if (!(m_valid && wait_in)) begin
      m_valid = acc && !wr;
      if (m_valid) exp_q.push_back(resp_of(packet_in, reg_val(idx, s_now)));
    end
    if (acc && wr) begin
      case (idx)
        0: m_out = wd;
        1: m_dir = wd;
        3: m_out = m_out | wd;
        4: m_out = m_out & ~wd;
        5: m_out = m_out ^ wd;
        6: m_imask = wd;
        7: m_itype = wd;
        8: m_ipol = wd;
`ifdef GPIO_IRQ_BOTHEDGE_EN
        10: m_iboth = wd;
`endif
        default: ;
      endcase
    end
    m_ilat = nl;
    pin_q.push_front(gpio_in);
    if (pin_q.size() > 3) void'(pin_q.pop_back());
  endtask

  initial forever begin
    @(posedge clk or negedge nreset);
    model_step();
  end

  task automatic monitor_step();
    check("access_out", PW'(access_out), PW'(m_valid));
    check("wait_out", PW'(wait_out), PW'(m_valid & wait_in));
    check("gpio_out", PW'(gpio_out), PW'(m_out));
    check("gpio_dir", PW'(gpio_dir), PW'(m_dir));
    check("gpio_irq", PW'(gpio_irq), PW'(m_irq));
    if (access_out) begin
      if (exp_q.size() == 0) fail_now("resp_unexpected");
      else begin
        check("resp_pkt", packet_out, exp_q[0]);
        if (!wait_in) void'(exp_q.pop_front());
      end
    end
  endtask

  initial forever begin
    @(negedge clk);
    monitor_step();
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input bit wr, input int idx, input logic [31:0] data, input logic [31:0] src);
    packet_in = make_pkt(wr, idx, data, src);
    access_in = 1'b1;
    tick(1);
    access_in = 1'b0;
  endtask

  task automatic read_reg(input int idx, input logic [31:0] src, output logic [31:0] data);
    send(1'b0, idx, 32'h0, src);
    for (int k = 0; k < 8 && !access_out; k++) tick(1);
    if (!access_out) fail_now("read_timeout");
    data = packet_out[71:40];
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [31:0] d, s1, s2;

  initial begin
    nreset = 1'b0; access_in = 1'b0; wait_in = 1'b0; gpio_in = '0; packet_in = '0;
    tick(3);
    check("rst_access_out", PW'(access_out), PW'(1'b0));
    check("rst_packet_out", packet_out, PW'(0));
    check("rst_gpio_irq", PW'(gpio_irq), PW'(1'b0));
    check("rst_gpio_dir", PW'(gpio_dir), PW'(0));
    nreset = 1'b1;
    tick(4);

    // OUT bit operations
    send(1'b1, 0, 32'h0000_00F0, 32'h0);
    send(1'b1, 3, 32'h0000_0001, 32'h0);
    send(1'b1, 4, 32'h0000_0010, 32'h0);
    send(1'b1, 5, 32'h0000_0300, 32'h0);
    check("out_ops_gpio_out", PW'(gpio_out), PW'(16'h03E1));
    read_reg(0, 32'hA5A5_1234, d);
    check("out_read_data", PW'(d), PW'(32'h3E1));
    check("out_read_dst", PW'(packet_out[39:8]), PW'(32'hA5A5_1234));
    tick(1);

    // rising-edge interrupt on pin 0
    send(1'b1, 6, 32'h0000_FFFE, 32'h0);
    send(1'b1, 8, 32'h0000_0001, 32'h0);
    send(1'b1, 7, 32'h0000_0001, 32'h0);
    send(1'b1, 9, 32'h0000_0001, 32'h0);
    tick(3);
    gpio_in[0] = 1'b1;
    tick(3);
    check("edge_irq_early", PW'(gpio_irq), PW'(1'b0));
    tick(1);
    check("edge_irq_set", PW'(gpio_irq), PW'(1'b1));
    read_reg(9, 32'h1111_0000, d);
    check("edge_ilat0", PW'(d[0]), PW'(1'b1));
    tick(1);
    send(1'b1, 9, 32'h0000_0001, 32'h0);
    tick(1);
    check("edge_irq_clear", PW'(gpio_irq), PW'(1'b0));

    // level-low interrupt on pin 3
    gpio_in = '0;
    send(1'b1, 7, 32'h0, 32'h0);
    send(1'b1, 8, 32'h0, 32'h0);
    send(1'b1, 6, 32'h0000_FFF7, 32'h0);
    tick(4);
    check("level_irq_on", PW'(gpio_irq), PW'(1'b1));
    send(1'b1, 6, 32'h0000_FFFF, 32'h0);
    tick(2);
    check("level_irq_masked", PW'(gpio_irq), PW'(1'b0));

    // response stall
    s1 = 32'hCAFE_0001; s2 = 32'hCAFE_0002;
    wait_in = 1'b1;
    send(1'b0, 1, 32'h0, s1);
    packet_in = make_pkt(1'b0, 0, 32'h0, s2);
    access_in = 1'b1;
    for (int k = 0; k < 3; k++) begin
      check("stall_wait_out", PW'(wait_out), PW'(1'b1));
      check("stall_hold_dst", PW'(packet_out[39:8]), PW'(s1));
      if (k < 2) tick(1);
    end
    wait_in = 1'b0;
    tick(1);
    access_in = 1'b0;
    check("stall_second_valid", PW'(access_out), PW'(1'b1));
    check("stall_second_dst", PW'(packet_out[39:8]), PW'(s2));
    tick(2);

    // same-cycle edge set and ILAT clear on pin 1
    gpio_in = '0;
    send(1'b1, 8, 32'h0000_0002, 32'h0);
    send(1'b1, 7, 32'h0000_0002, 32'h0);
    send(1'b1, 9, 32'h0000_0002, 32'h0);
    tick(3);
    gpio_in[1] = 1'b1;
    tick(2);
    send(1'b1, 9, 32'h0000_0002, 32'h0);
    read_reg(9, 32'h2222_0000, d);
    check("setwins_ilat1", PW'(d[1]), PW'(1'b1));
    tick(1);

    // reset while a response is pending
    wait_in = 1'b1;
    send(1'b0, 0, 32'h0, 32'h3333_0000);
    nreset = 1'b0;
    #1;
    check("midrst_access_out", PW'(access_out), PW'(1'b0));
    check("midrst_packet_out", packet_out, PW'(0));
    check("midrst_gpio_out", PW'(gpio_out), PW'(0));
    tick(2);
    wait_in = 1'b0;
    nreset = 1'b1;
    tick(4);

`ifdef GPIO_IRQ_BOTHEDGE_EN
    gpio_in = '0;
    send(1'b1, 10, 32'h0000_0004, 32'h0);
    send(1'b1, 7, 32'h0000_0004, 32'h0);
    send(1'b1, 9, 32'h0000_0004, 32'h0);
    tick(3);
    gpio_in[2] = 1'b1;
    tick(4);
    read_reg(9, 32'h4444_0000, d);
    check("both_rise_ilat2", PW'(d[2]), PW'(1'b1));
    tick(1);
    send(1'b1, 9, 32'h0000_0004, 32'h0);
    gpio_in[2] = 1'b0;
    tick(4);
    read_reg(9, 32'h4444_0001, d);
    check("both_fall_ilat2", PW'(d[2]), PW'(1'b1));
    tick(1);
`else
    send(1'b1, 10, 32'hFFFF_FFFF, 32'h0);
    read_reg(10, 32'h5555_0000, d);
    check("reg10_reads_zero", PW'(d), PW'(0));
    tick(1);
`endif

    // randomized traffic
    for (int c = 0; c < 600; c++) begin
      wait_in = ($urandom_range(3, 0) == 0);
      if ($urandom_range(7, 0) == 0) gpio_in = N'($urandom);
      if ($urandom_range(1, 0) == 1) begin
        packet_in = make_pkt(bit'($urandom_range(1, 0)), int'($urandom_range(11, 0)),
                             $urandom, $urandom);
        access_in = 1'b1;
      end else begin
        access_in = 1'b0;
      end
      tick(1);
    end
    access_in = 1'b0;
    wait_in = 1'b0;
    tick(5);
    check("drain_queue_empty", PW'(exp_q.size()), PW'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
